// File: rtl/hdr_frame_tx_if.sv
// Frame transmitter bus: host-side request/capture signals and serial link outputs.
// master = host driving requests and receiving the serial stream; slave = hdr_frame_tx.
interface hdr_frame_tx_if #(
    parameter int unsigned PAYLOAD_W = 16
) ();
    logic                 start;
    logic [4:0]           preamble;
    logic [PAYLOAD_W-1:0] payload;
    logic                 hold;
    logic [1:0]           err_inj;
    logic                 ready;
    logic                 tx_bit;
    logic                 tx_valid;
    logic                 tx_sof;
    logic                 tx_eof;
    logic                 done;

    modport master (
        output start, preamble, payload, hold, err_inj,
        input  ready, tx_bit, tx_valid, tx_sof, tx_eof, done
    );

    modport slave (
        input  start, preamble, payload, hold, err_inj,
        output ready, tx_bit, tx_valid, tx_sof, tx_eof, done
    );
endinterface

// File: rtl/hdr_frame_tx.sv
// Serial frame transmitter: 32-bit LFSR header seeded from a 5-bit preamble, then the
// payload, one bit per clock, LSB first. All outputs are registered.
// Optional build macro ERR_INJECT_EN: inverts the first err_inj header bits on the wire.
module hdr_frame_tx #(
    parameter int unsigned PAYLOAD_W  = 16,
    parameter int unsigned GAP_CYCLES = 2
) (
    input logic          clk,
    input logic          rst,
    hdr_frame_tx_if.slave bus
);
    localparam int unsigned JW = $clog2(PAYLOAD_W + 1);
    localparam logic [JW-1:0] PAY_LAST = JW'(PAYLOAD_W - 1);
    localparam logic [JW-1:0] PAY_END  = JW'(PAYLOAD_W);
    localparam logic [3:0]    GAP_LAST = 4'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StHdr, StPay, StDone, StGap} state_e;

    state_e               state;
    logic [4:0]           sr;       // LFSR state for the next header bit
    logic [5:0]           i;        // index of the next header bit to send
    logic [PAYLOAD_W-1:0] pay_sr;
    logic [JW-1:0]        j;        // count of payload bits already sent
    logic [3:0]           gap_cnt;
    logic                 ready_q;
    logic                 bit_q;
    logic                 valid_q;
    logic                 sof_q;
    logic                 eof_q;
    logic                 done_q;

    logic [1:0] inj_cnt;            // header bits still to be inverted, from bit 0
    logic       inj_first;          // invert header bit 0 (sent on the accept edge)
    logic       flip;

`ifdef ERR_INJECT_EN
    logic [1:0] inj_q;

    // Capture the injection count with the frame request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inj_q <= 2'd0;
        end else if (state == StIdle && bus.start) begin
            inj_q <= bus.err_inj;
        end
    end

    assign inj_cnt   = inj_q;
    assign inj_first = (bus.err_inj != 2'd0);
`else
    logic unused_err_inj;
    assign unused_err_inj = ^bus.err_inj;
    assign inj_cnt        = 2'd0;
    assign inj_first      = 1'b0;
`endif

    assign flip = (i < {4'd0, inj_cnt});

    // Frame FSM; every output is registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= StIdle;
            sr      <= 5'd0;
            i       <= 6'd0;
            pay_sr  <= '0;
            j       <= '0;
            gap_cnt <= 4'd0;
            ready_q <= 1'b1;
            bit_q   <= 1'b0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            sof_q  <= 1'b0;
            eof_q  <= 1'b0;
            done_q <= 1'b0;
            unique case (state)
                StIdle: begin
                    valid_q <= 1'b0;
                    if (bus.start) begin
                        // Bit 0 leaves on the accept edge so tx_sof shows the next cycle;
                        // the LFSR is stepped once here to line up with i = 1.
                        bit_q   <= bus.preamble[0] ^ inj_first;
                        valid_q <= 1'b1;
                        sof_q   <= 1'b1;
                        ready_q <= 1'b0;
                        sr      <= {bus.preamble[0] ^ bus.preamble[3], bus.preamble[4:1]};
                        i       <= 6'd1;
                        pay_sr  <= bus.payload;
                        j       <= '0;
                        state   <= StHdr;
                    end
                end
                StHdr: begin
                    if (bus.hold) begin
                        valid_q <= 1'b0;
                    end else begin
                        valid_q <= 1'b1;
                        if (i == 6'd31) begin
                            // Last header bit is a fixed zero; LFSR does not advance.
                            bit_q <= 1'b0;
                            state <= StPay;
                        end else begin
                            bit_q <= sr[0] ^ flip;
                            sr    <= {sr[0] ^ sr[3], sr[4:1]};
                            i     <= i + 6'd1;
                        end
                    end
                end
                StPay: begin
                    if (j == PAY_END) begin
                        valid_q <= 1'b0;
                        bit_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state   <= StDone;
                    end else if (bus.hold) begin
                        valid_q <= 1'b0;
                    end else begin
                        valid_q <= 1'b1;
                        bit_q   <= pay_sr[0];
                        pay_sr  <= pay_sr >> 1;
                        eof_q   <= (j == PAY_LAST);
                        j       <= j + 1'b1;
                    end
                end
                StDone: begin
                    valid_q <= 1'b0;
                    gap_cnt <= 4'd0;
                    if (GAP_CYCLES == 0) begin
                        ready_q <= 1'b1;
                        state   <= StIdle;
                    end else begin
                        state <= StGap;
                    end
                end
                StGap: begin
                    if (gap_cnt == GAP_LAST) begin
                        ready_q <= 1'b1;
                        state   <= StIdle;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                    state   <= StIdle;
                end
            endcase
        end
    end

    assign bus.ready    = ready_q;
    assign bus.tx_bit   = bit_q;
    assign bus.tx_valid = valid_q;
    assign bus.tx_sof   = sof_q;
    assign bus.tx_eof   = eof_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_hdr_frame_tx.sv
// Directed bench for hdr_frame_tx: reset, basic frame, zero seed, hold, error injection,
// back-to-back requests and mid-frame reset.
module tb_hdr_frame_tx;
    localparam int unsigned PW  = 16;
    localparam int unsigned GAP = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hdr_frame_tx_if #(.PAYLOAD_W(PW)) bus ();

    hdr_frame_tx #(.PAYLOAD_W(PW), .GAP_CYCLES(GAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Captured frame.
    logic [31:0] hdr;
    logic [63:0] pay;
    logic [31:0] ref_hdr;
    logic        held_bit;
    int          nbits, sof_cyc, eof_cyc, done_cyc, n_idle;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Header reference: bit b = seed LFSR output, bit 31 forced zero, first inj bits inverted.
    function automatic logic [31:0] hdr_model(input logic [4:0] pre, input int inj);
        logic [4:0]  s;
        logic [31:0] h;
        s = pre;
        h = '0;
        for (int b = 0; b < 31; b++) begin
            h[b] = s[0] ^ (b < inj);
            s    = {s[0] ^ s[3], s[4:1]};
        end
        return h;
    endfunction

    task automatic wait_ready();
        int k;
        k = 0;
        while (!bus.ready && k < 60) begin
            @(negedge clk);
            k++;
        end
        check_eq("ready_wait", 64'(bus.ready), 64'd1);
    endtask

    // Send one frame; hold is driven high for edges ending cycles hold_at..hold_at+hold_len-1.
    task automatic run_frame(input logic [4:0] pre, input logic [PW-1:0] pl,
                             input logic [1:0] inj, input int hold_at, input int hold_len);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.preamble = pre;
        bus.payload  = pl;
        bus.err_inj  = inj;
        @(negedge clk);
        bus.start = 1'b0;
        nbits = 0; sof_cyc = -1; eof_cyc = -1; done_cyc = -1; n_idle = 0;
        hdr = '0; pay = '0; held_bit = 1'bx;
        for (int k = 1; k <= 120 && done_cyc < 0; k++) begin
            if (bus.tx_valid) begin
                if (nbits < 32) hdr[nbits] = bus.tx_bit;
                else if (nbits < 96) pay[nbits-32] = bus.tx_bit;
                nbits++;
            end else if (nbits > 0 && eof_cyc < 0) begin
                n_idle++;
                held_bit = bus.tx_bit;
            end
            if (bus.tx_sof && sof_cyc < 0) sof_cyc = k;
            if (bus.tx_eof) eof_cyc = k;
            if (bus.done) done_cyc = k;
            bus.hold = (k >= hold_at && k < hold_at + hold_len);
            @(negedge clk);
        end
        bus.hold = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d1, s1, s2, n_sof_pre, n_done;
        bus.start = 1'b0; bus.preamble = '0; bus.payload = '0; bus.hold = 1'b0;
        bus.err_inj = 2'd0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", 64'(bus.ready), 64'd1);
        check_eq("rst_valid", 64'(bus.tx_valid), 64'd0);
        check_eq("rst_done", 64'(bus.done), 64'd0);
        check_eq("rst_bit", 64'(bus.tx_bit), 64'd0);
        check_eq("rst_sof_eof", 64'({bus.tx_sof, bus.tx_eof}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic frame.
        wait_ready();
        run_frame(5'b00001, 16'hA5C3, 2'd0, -10, 0);
        ref_hdr = hdr;
        check_eq("basic_hdr_0_6", 64'(hdr[6:0]), 64'b0100001);
        check_eq("basic_hdr_31", 64'(hdr[31]), 64'd0);
        check_eq("basic_hdr", 64'(hdr), 64'(hdr_model(5'b00001, 0)));
        check_eq("basic_pay", pay, 64'hA5C3);
        check_eq("basic_nbits", 64'(nbits), 64'd48);
        check_eq("basic_sof_cyc", 64'(sof_cyc), 64'd1);
        check_eq("basic_eof_cyc", 64'(eof_cyc), 64'd48);
        check_eq("basic_done_cyc", 64'(done_cyc), 64'd49);
        // Now in cycle 50: gap cycles 50 and 51, ready back in 52.
        check_eq("gap_ready_50", 64'(bus.ready), 64'd0);
        @(negedge clk);
        check_eq("gap_ready_51", 64'(bus.ready), 64'd0);
        @(negedge clk);
        check_eq("gap_ready_52", 64'(bus.ready), 64'd1);

        // Zero seed.
        wait_ready();
        run_frame(5'b00000, 16'hFFFF, 2'd0, -10, 0);
        check_eq("zero_hdr", 64'(hdr), 64'd0);
        check_eq("zero_pay", pay, 64'hFFFF);
        check_eq("zero_done_cyc", 64'(done_cyc), 64'd49);

        // Hold for 3 cycles where header bit 10 would go out.
        wait_ready();
        run_frame(5'b00001, 16'hA5C3, 2'd0, 10, 3);
        check_eq("hold_hdr", 64'(hdr), 64'(ref_hdr));
        check_eq("hold_pay", pay, 64'hA5C3);
        check_eq("hold_idle", 64'(n_idle), 64'd3);
        check_eq("hold_bit_kept", 64'(held_bit), 64'(ref_hdr[9]));
        check_eq("hold_eof_cyc", 64'(eof_cyc), 64'd51);
        check_eq("hold_done_cyc", 64'(done_cyc), 64'd52);

        // Error injection request of 2 bits.
        wait_ready();
        run_frame(5'b00001, 16'h1234, 2'd2, -10, 0);
`ifdef ERR_INJECT_EN
        check_eq("inj_hdr_0_1", 64'(hdr[1:0]), 64'b10);
        check_eq("inj_hdr_rest", 64'(hdr[31:2]), 64'(ref_hdr[31:2]));
`else
        check_eq("inj_off_hdr", 64'(hdr), 64'(ref_hdr));
`endif
        check_eq("inj_pay", pay, 64'h1234);

        // Back-to-back with start held high.
        wait_ready();
        @(negedge clk);
        bus.start = 1'b1; bus.preamble = 5'b00001; bus.payload = 16'hA5C3; bus.err_inj = 2'd0;
        d1 = -1; s1 = -1; s2 = -1; n_sof_pre = 0;
        for (int k = 1; k <= 150 && s2 < 0; k++) begin
            @(negedge clk);
            if (bus.tx_sof) begin
                if (d1 < 0) begin
                    n_sof_pre++;
                    if (s1 < 0) s1 = k;
                end else begin
                    s2 = k;
                end
            end
            if (bus.done && d1 < 0) d1 = k;
        end
        bus.start = 1'b0;
        check_eq("b2b_sof1", 64'(s1), 64'd1);
        check_eq("b2b_done1", 64'(d1), 64'd49);
        check_eq("b2b_sof_once", 64'(n_sof_pre), 64'd1);
        check_eq("b2b_sof2_gap", 64'(s2 - d1), 64'd4);

        // Reset while in the header.
        wait_ready();
        @(negedge clk);
        bus.start = 1'b1; bus.preamble = 5'b10110; bus.payload = 16'h0F0F;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("pre_rst_valid", 64'(bus.tx_valid), 64'd1);
        #1 rst = 1'b1;
        #1;
        check_eq("mid_rst_valid", 64'(bus.tx_valid), 64'd0);
        check_eq("mid_rst_ready", 64'(bus.ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus.done || bus.tx_eof) n_done++;
        end
        check_eq("mid_rst_no_done", 64'(n_done), 64'd0);
        wait_ready();
        run_frame(5'b00001, 16'hA5C3, 2'd0, -10, 0);
        check_eq("post_rst_hdr", 64'(hdr), 64'(ref_hdr));
        check_eq("post_rst_pay", pay, 64'hA5C3);
        check_eq("post_rst_done", 64'(done_cyc), 64'd49);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
